// File: rtl/pipeline_stall_controller_pkg.sv
// pipeline_stall_controller_pkg: shared state encoding and default memory timeout
package pipeline_stall_controller_pkg;
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN = 2'd1;
  localparam logic [1:0] MEM_WAIT = 2'd2;
  localparam logic [1:0] HALT = 2'd3;
  localparam int DEF_MEM_TIMEOUT = 16;
endpackage

// File: rtl/pipeline_stall_controller_if.sv
// pipeline_stall_controller_if: hazard inputs and pipeline-register controls of the stall controller
interface pipeline_stall_controller_if #(parameter int CNT_W = 32);
  logic start, load_use_hazard, branch_taken_ex, dmem_req, dmem_ready;
  logic pc_write, if_id_write, if_id_flush, id_ex_flush, ex_mem_write, mem_wb_write;
  logic mem_timeout_err;
  logic [CNT_W-1:0] stall_cycles;
  logic [15:0] flush_count;
  modport master (
    output start, load_use_hazard, branch_taken_ex, dmem_req, dmem_ready,
    input pc_write, if_id_write, if_id_flush, id_ex_flush, ex_mem_write, mem_wb_write,
    input mem_timeout_err, stall_cycles, flush_count
  );
  modport slave (
    input start, load_use_hazard, branch_taken_ex, dmem_req, dmem_ready,
    output pc_write, if_id_write, if_id_flush, id_ex_flush, ex_mem_write, mem_wb_write,
    output mem_timeout_err, stall_cycles, flush_count
  );
endinterface

// File: rtl/pipeline_stall_controller_sat_counter.sv
// sat_counter: up-counter that sticks at all-ones
module sat_counter #(parameter int W = 16) (
  input logic clk,
  input logic arst,
  input logic inc,
  output logic [W-1:0] count
);
  always_ff @(posedge clk or posedge arst)
    if (arst) count <= '0;
    else if (inc && ~&count) count <= count + 1'b1;
endmodule

// File: rtl/pipeline_stall_controller.sv
// pipeline_stall_controller: freeze/flush/stall decode for a 5-stage pipeline with memory timeout
module pipeline_stall_controller
  import pipeline_stall_controller_pkg::*;
#(
  parameter int MEM_TIMEOUT = DEF_MEM_TIMEOUT,
  parameter int CNT_W = 32
) (
  input logic clk,
  input logic arst,
  pipeline_stall_controller_if.slave bus
);
  logic [1:0] state, state_nx;
  logic [7:0] wcnt;
  logic run_rules, br, lu, pc_w, stall_inc, flush_inc;
  always_comb begin
    br = bus.branch_taken_ex;
    lu = bus.load_use_hazard;
    // the MEM_WAIT release cycle behaves exactly like an unfrozen RUN cycle
    run_rules = (state == RUN && !(bus.dmem_req && !bus.dmem_ready)) || (state == MEM_WAIT && bus.dmem_ready);
    pc_w = run_rules && (br || !lu);
    bus.pc_write = pc_w;
    bus.if_id_write = pc_w;
    bus.if_id_flush = run_rules && br;
    bus.id_ex_flush = run_rules && (br || lu);
    bus.ex_mem_write = run_rules;
    bus.mem_wb_write = run_rules;
    bus.mem_timeout_err = state == HALT;
    stall_inc = (state == RUN || state == MEM_WAIT) && !pc_w;
    flush_inc = run_rules && br;
    state_nx = state == IDLE ? (bus.start ? RUN : IDLE)
             : state == RUN ? (bus.dmem_req && !bus.dmem_ready ? MEM_WAIT : RUN)
             : state == MEM_WAIT ? (bus.dmem_ready ? RUN : wcnt == 8'(MEM_TIMEOUT - 1) ? HALT : MEM_WAIT)
             : HALT;
  end
  always_ff @(posedge clk or posedge arst)
    if (arst) begin
      state <= IDLE;
      wcnt <= '0;
    end else begin
      state <= state_nx;
      wcnt <= state != MEM_WAIT ? 8'd0 : !bus.dmem_ready ? wcnt + 8'd1 : wcnt;
    end
  sat_counter #(.W(CNT_W)) u_stall (.clk(clk), .arst(arst), .inc(stall_inc), .count(bus.stall_cycles));
  sat_counter #(.W(16)) u_flush (.clk(clk), .arst(arst), .inc(flush_inc), .count(bus.flush_count));
endmodule

// File: tb/tb_pipeline_stall_controller.sv
// tb_pipeline_stall_controller: directed scenarios with a queued expectation scoreboard
module tb_pipeline_stall_controller;
  typedef struct {
    string tag;
    logic [6:0] out;
    int stall;
    int flush;
  } exp_t;
  localparam logic [6:0] Z = 7'b0000000;
  localparam logic [6:0] RUNO = 7'b1100110;
  localparam logic [6:0] LU = 7'b0001110;
  localparam logic [6:0] BR = 7'b1111110;
  localparam logic [6:0] HLT = 7'b0000001;
  logic clk = 0, arst = 1;
  int checks = 0, errors = 0;
  exp_t q[$];
  pipeline_stall_controller_if #(.CNT_W(32)) bus ();
  pipeline_stall_controller #(.MEM_TIMEOUT(4), .CNT_W(32)) dut (.clk(clk), .arst(arst), .bus(bus));
  always #5 clk = ~clk;
  wire [6:0] outs = {bus.pc_write, bus.if_id_write, bus.if_id_flush, bus.id_ex_flush,
                     bus.ex_mem_write, bus.mem_wb_write, bus.mem_timeout_err};
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic chk_all(input string tag, input logic [6:0] o, input int s, input int f);
    chk({tag, ".out"}, 64'(outs), 64'(o));
    chk({tag, ".stall"}, 64'(bus.stall_cycles), 64'(s));
    chk({tag, ".flush"}, 64'(bus.flush_count), 64'(f));
  endtask
  task automatic cyc(input string tag, input logic st, lu, br, rq, rd, input logic [6:0] o, input int s, input int f);
    exp_t e;
    bus.start = st;
    bus.load_use_hazard = lu;
    bus.branch_taken_ex = br;
    bus.dmem_req = rq;
    bus.dmem_ready = rd;
    q.push_back('{tag, o, s, f});
    @(negedge clk);
    e = q.pop_front();
    chk_all(e.tag, e.out, e.stall, e.flush);
    @(posedge clk);
    #1;
  endtask
  initial begin
    bus.start = 0;
    bus.load_use_hazard = 0;
    bus.branch_taken_ex = 0;
    bus.dmem_req = 0;
    bus.dmem_ready = 0;
    @(posedge clk);
    #1;
    cyc("reset", 1, 1, 1, 1, 1, Z, 0, 0);
    arst = 0;
    cyc("idle", 0, 1, 1, 1, 0, Z, 0, 0);
    cyc("start", 1, 0, 0, 0, 0, Z, 0, 0);
    for (int i = 0; i < 10; i++) cyc("run", 0, 0, 0, 0, 0, RUNO, 0, 0);
    cyc("loaduse", 0, 1, 0, 0, 0, LU, 0, 0);
    cyc("after_lu", 0, 0, 0, 0, 0, RUNO, 1, 0);
    cyc("br_over_lu", 0, 1, 1, 0, 0, BR, 1, 0);
    cyc("after_br", 0, 0, 0, 0, 0, RUNO, 1, 1);
    cyc("single_mem", 0, 0, 0, 1, 1, RUNO, 1, 1);
    cyc("freeze0", 0, 0, 0, 1, 0, Z, 1, 1);
    cyc("freeze1", 0, 0, 1, 1, 0, Z, 2, 1);
    cyc("freeze2", 0, 1, 1, 1, 0, Z, 3, 1);
    cyc("release_br", 0, 1, 1, 1, 1, BR, 4, 1);
    cyc("after_rel", 0, 0, 0, 0, 0, RUNO, 4, 2);
    cyc("to_entry", 0, 0, 0, 1, 0, Z, 4, 2);
    for (int i = 0; i < 4; i++) cyc("to_wait", 0, 0, 0, 1, 0, Z, 5 + i, 2);
    cyc("halt_start", 1, 0, 0, 0, 1, HLT, 9, 2);
    cyc("halt_hold", 0, 0, 1, 1, 1, HLT, 9, 2);
    arst = 1;
    #1;
    chk_all("arst_halt", Z, 0, 0);
    #2;
    arst = 0;
    cyc("post_halt", 0, 0, 0, 1, 1, Z, 0, 0);
    cyc("start2", 1, 0, 0, 0, 0, Z, 0, 0);
    cyc("br2", 0, 0, 1, 0, 0, BR, 0, 0);
    cyc("enter_wait", 0, 0, 0, 1, 0, Z, 0, 1);
    bus.dmem_req = 1;
    bus.dmem_ready = 0;
    arst = 1;
    #1;
    chk_all("arst_wait", Z, 0, 0);
    #2;
    arst = 0;
    cyc("idle_after", 0, 0, 0, 1, 1, Z, 0, 0);
    cyc("start3", 1, 0, 0, 0, 0, Z, 0, 0);
    cyc("run3", 0, 0, 0, 0, 0, RUNO, 0, 0);
    chk("queue_empty", 64'(q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
